// File: rtl/fir_chan_scheduler_if.sv
// Signal bundle around the FIR channel scheduler; _i/_o suffixes are named from
// the scheduler's point of view (master), the environment uses the slave modport.
interface fir_chan_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0]   ready_i;
  logic [NCH*8-1:0] x_i;
  logic             clear_err_i;
  logic             eng_start_o;
  logic [7:0]       eng_x_o;
  logic [CW-1:0]    eng_chan_o;
  logic             eng_done_i;
  logic [17:0]      eng_y_i;
  logic [17:0]      y_out_o;
  logic [CW-1:0]    y_chan_o;
  logic             y_valid_o;
  logic             busy_o;
  logic [NCH-1:0]   overrun_o;
  logic             timeout_err_o;

  modport master (
    input  ready_i, x_i, clear_err_i, eng_done_i, eng_y_i,
    output eng_start_o, eng_x_o, eng_chan_o, y_out_o, y_chan_o, y_valid_o,
           busy_o, overrun_o, timeout_err_o
  );

  modport slave (
    output ready_i, x_i, clear_err_i, eng_done_i, eng_y_i,
    input  eng_start_o, eng_x_o, eng_chan_o, y_out_o, y_chan_o, y_valid_o,
           busy_o, overrun_o, timeout_err_o
  );
endinterface

// File: rtl/fir_chan_scheduler.sv
// Round-robin scheduler sharing one FIR engine between NCH channels: captures
// samples, issues tagged engine jobs, returns tagged results, flags overruns/hangs.
module fir_chan_scheduler #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fir_chan_scheduler_if.master  bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            eng_start_q, eng_start_d;
  logic [7:0]      eng_x_q, eng_x_d;
  logic [CW-1:0]   eng_chan_q, eng_chan_d;
  logic [17:0]     y_out_q, y_out_d;
  logic [CW-1:0]   y_chan_q, y_chan_d;
  logic            y_valid_q, y_valid_d;
  logic            timeout_err_q, timeout_err_d;
  logic            timeout_set;

  logic [NCH-1:0]  pend_vec;
  logic [NCH-1:0]  overrun_vec;
  logic [7:0]      hold_vec [NCH];
  logic            grant_vld;
  logic [CW-1:0]   grant_idx;
  logic            grant_fire;

  function automatic logic [CW-1:0] chan_add(input logic [CW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  // First pending channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_vld && pend_vec[chan_add(rr_ptr_q, i)]) begin
        grant_vld = 1'b1;
        grant_idx = chan_add(rr_ptr_q, i);
      end
    end
  end

  assign grant_fire = (state_q == S_IDLE) && grant_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic [7:0] hold_q;
      logic       pend_q;
      logic       overrun_q;
      logic       granted;

      assign granted = grant_fire && (grant_idx == CW'(gi));

      // A fresh sample on the grant edge re-arms pend instead of counting as overrun.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          hold_q    <= 8'd0;
          pend_q    <= 1'b0;
          overrun_q <= 1'b0;
        end else begin
          if (bus.ready_i[gi]) begin
            hold_q <= bus.x_i[8*gi +: 8];
            pend_q <= 1'b1;
          end else if (granted) begin
            pend_q <= 1'b0;
          end
          if (bus.ready_i[gi] && pend_q && !granted) begin
            overrun_q <= 1'b1;
          end else if (bus.clear_err_i) begin
            overrun_q <= 1'b0;
          end
        end
      end

      assign pend_vec[gi]    = pend_q;
      assign overrun_vec[gi] = overrun_q;
      assign hold_vec[gi]    = hold_q;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    eng_start_d = 1'b0;
    eng_x_d     = eng_x_q;
    eng_chan_d  = eng_chan_q;
    y_out_d     = y_out_q;
    y_chan_d    = y_chan_q;
    y_valid_d   = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          eng_x_d     = hold_vec[grant_idx];
          eng_chan_d  = grant_idx;
          eng_start_d = 1'b1;
          rr_ptr_d    = chan_add(grant_idx, 1);
          wdog_d      = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        // Completion on the last watchdog cycle still counts as a good result.
        if (bus.eng_done_i) begin
          y_out_d   = bus.eng_y_i;
          y_chan_d  = eng_chan_q;
          y_valid_d = 1'b1;
          state_d   = S_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    timeout_err_d = timeout_set | (timeout_err_q & ~bus.clear_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      eng_start_q   <= 1'b0;
      eng_x_q       <= 8'd0;
      eng_chan_q    <= '0;
      y_out_q       <= 18'd0;
      y_chan_q      <= '0;
      y_valid_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      eng_start_q   <= eng_start_d;
      eng_x_q       <= eng_x_d;
      eng_chan_q    <= eng_chan_d;
      y_out_q       <= y_out_d;
      y_chan_q      <= y_chan_d;
      y_valid_q     <= y_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.eng_start_o   = eng_start_q;
  assign bus.eng_x_o       = eng_x_q;
  assign bus.eng_chan_o    = eng_chan_q;
  assign bus.y_out_o       = y_out_q;
  assign bus.y_chan_o      = y_chan_q;
  assign bus.y_valid_o     = y_valid_q;
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.overrun_o     = overrun_vec;
  assign bus.timeout_err_o = timeout_err_q;
endmodule
